// File: rtl/invntt_tomont_32bit.sv
// rtl/invntt_tomont_32bit.sv - Dilithium inverse NTT with Montgomery scaling, one butterfly per cycle
module invntt_tomont_32bit #(
   parameter int Q    = 8380417,
   parameter int QINV = 58728449,
   parameter int F    = 41978
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic signed [0:8191] inp,
   output logic                 rd_ready,
   output logic                 rd_done,
   output logic                 done,
   output logic                 wr_done,
   output logic signed [0:8191] out
);
   typedef enum logic [2:0] {IDLE, WAIT_START, RD_INP, BFLY, SCALE, WR_OUT, DONE} state_t;

   // Forward-NTT twiddles in Montgomery form, bit-reversed order; the inverse walks them backwards
   localparam logic signed [31:0] ZETAS [256] = '{
         0,    25847, -2608894,  -518909,   237124,  -777960,  -876248,   466468,
   1826347,  2353451,  -359251, -2091905,  3119733, -2884855,  3111497,  2680103,
   2725464,  1024112, -1079900,  3585928,  -549488, -1119584,  2619752, -2108549,
  -2118186, -3859737, -1399561, -3277672,  1757237,   -19422,  4010497,   280005,
   2706023,    95776,  3077325,  3530437, -1661693, -3592148, -2537516,  3915439,
  -3861115, -3043716,  3574422, -2867647,  3539968,  -300467,  2348700,  -539299,
  -1699267, -1643818,  3505694, -3821735,  3507263, -2140649, -1600420,  3699596,
    811944,   531354,   954230,  3881043,  3900724, -2556880,  2071892, -2797779,
  -3930395, -1528703, -3677745, -3041255, -1452451,  3475950,  2176455, -1585221,
  -1257611,  1939314, -4083598, -1000202, -3190144, -3157330, -3632928,   126922,
   3412210,  -983419,  2147896,  2715295, -2967645, -3693493,  -411027, -2477047,
   -671102, -1228525,   -22981, -1308169,  -381987,  1349076,  1852771, -1430430,
  -3343383,   264944,   508951,  3097992,    44288, -1100098,   904516,  3958618,
  -3724342,    -8578,  1653064, -3249728,  2389356,  -210977,   759969, -1316856,
    189548, -3553272,  3159746, -1851402, -2409325,  -177440,  1315589,  1341330,
   1285669, -1584928,  -812732, -1439742, -3019102, -3881060, -3628969,  3839961,
   2091667,  3407706,  2316500,  3817976, -3342478,  2244091, -2446433, -3562462,
    266997,  2434439, -1235728,  3513181, -3520352, -3759364, -1197226, -3193378,
    900702,  1859098,   909542,   819034,   495491, -1613174,   -43260,  -522500,
   -655327, -3122442,  2031748,  3207046, -3556995,  -525098,  -768622, -3595838,
    342297,   286988, -2437823,  4108315,  3437287, -3342277,  1735879,   203044,
   2842341,  2691481, -2590150,  1265009,  4055324,  1247620,  2486353,  1595974,
  -3767016,  1250494,  2635921, -3548272, -2994039,  1869119,  1903435, -1050970,
  -1333058,  1237275, -3318210, -1430225,  -451100,  1312455,  3306115, -1962642,
  -1279661,  1917081, -2546312, -1374803,  1500165,   777191,  2235880,  3406031,
   -542412, -2831860, -1671176, -1846953, -2584293, -3724270,   594136, -3776993,
  -2013608,  2432395,  2454455,  -164721,  1957272,  3369112,   185531, -1207385,
  -3183426,   162844,  1616392,  3014001,   810149,  1652634, -3694233, -1799107,
  -3038916,  3523897,  3866901,   269760,  2213111,  -975884,  1717735,   472078,
   -426683,  1723600, -1803090,  1910376, -1667432, -1104333,  -260646, -3833893,
  -2939036, -2235985,  -420899, -2286327,   183443,  -976891,  1612842, -3545687,
   -554416,  3919660,   -48306, -1362209,  3937738,  1400424,  -846154,  1976782
   };

   state_t             state, next_state;
   logic [2:0]         l;
   logic [6:0]         b, s;
   logic signed [31:0] a [256];

   logic [7:0]         len, g, j, jp, k;
   logic signed [31:0] t, u, sum, diff, zeta, bfly_lo, sc_even, sc_odd;
   logic signed [63:0] prod;

   // Low 32 bits of x - m*Q cancel by construction, so the arithmetic shift is exact
   function automatic logic signed [31:0] mont(input logic signed [63:0] x);
      logic signed [31:0] m;
      m = x[31:0] * QINV[31:0];
      return 32'((x - 64'(m) * 64'(Q)) >>> 32);
   endfunction

   always_comb begin
      len     = 8'd1 << l;
      g       = {1'b0, b} >> l;
      j       = (g << ({1'b0, l} + 4'd1)) | ({1'b0, b} & (len - 8'd1));
      jp      = j + len;
      k       = 8'((9'd256 >> l) - 9'd1 - {1'b0, g});
      t       = a[j];
      u       = a[jp];
      sum     = t + u;
      diff    = t - u;
      zeta    = ZETAS[k];
      prod    = -(64'(zeta)) * 64'(diff);
      bfly_lo = mont(prod);
      sc_even = mont(64'(a[{s, 1'b0}]) * 64'(F));
      sc_odd  = mont(64'(a[{s, 1'b1}]) * 64'(F));
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:       next_state = WAIT_START;
         WAIT_START: if (start) next_state = RD_INP;
         RD_INP:     next_state = BFLY;
         BFLY:       if (l == 3'd7 && b == 7'd127) next_state = SCALE;
         SCALE:      if (s == 7'd127) next_state = WR_OUT;
         WR_OUT:     next_state = DONE;
         DONE:       next_state = WAIT_START;
         default:    next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ready <= 1'b0;
         rd_done  <= 1'b0;
         done     <= 1'b0;
         wr_done  <= 1'b0;
         l        <= '0;
         b        <= '0;
         s        <= '0;
         out      <= '0;
      end else begin
         case (state)
            WAIT_START: if (start) begin
               rd_ready <= 1'b1;
               rd_done  <= 1'b0;
               wr_done  <= 1'b0;
            end
            RD_INP: begin
               rd_ready <= 1'b0;
               rd_done  <= 1'b1;
               l        <= '0;
               b        <= '0;
            end
            BFLY: begin
               if (b == 7'd127) begin
                  b <= '0;
                  l <= l + 3'd1;
                  s <= '0;
               end else begin
                  b <= b + 7'd1;
               end
            end
            SCALE: s <= s + 7'd1;
            WR_OUT: begin
               for (int i = 0; i < 256; i++) out[i*32 +: 32] <= a[i];
               done    <= 1'b1;
               wr_done <= 1'b1;
            end
            DONE: done <= 1'b0;
            default: ;
         endcase
      end
   end

   // Coefficient store carries no reset: its contents only matter after RD_INP refills it
   always_ff @(posedge clock) begin
      case (state)
         RD_INP: for (int i = 0; i < 256; i++) a[i] <= inp[i*32 +: 32];
         BFLY: begin
            a[j]  <= sum;
            a[jp] <= bfly_lo;
         end
         SCALE: begin
            a[{s, 1'b0}] <= sc_even;
            a[{s, 1'b1}] <= sc_odd;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_invntt_tomont_32bit.sv
// tb/tb_invntt_tomont_32bit.sv - randomized bench for invntt_tomont_32bit against a C-style reference
module tb_invntt_tomont_32bit;
   localparam int     Q          = 8380417;
   localparam longint R_MOD_Q    = 4193792;
   localparam int     LAT        = 1154;
   localparam int     PERIOD     = 1156;
   localparam int     NUM_RANDOM = 40;

   logic                 clock = 1'b0;
   logic                 reset = 1'b0;
   logic                 start = 1'b0;
   logic signed [0:8191] inp   = '0;
   logic                 rd_ready, rd_done, done, wr_done;
   logic signed [0:8191] out;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int zetas [256];

   invntt_tomont_32bit dut (
      .clock(clock), .reset(reset), .start(start), .inp(inp),
      .rd_ready(rd_ready), .rd_done(rd_done), .done(done), .wr_done(wr_done), .out(out)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint modq(input longint x);
      longint r;
      r = x % Q;
      if (r < 0) r += Q;
      return r;
   endfunction

   function automatic int mont(input longint x);
      int m;
      m = int'(x) * 58728449;
      return int'((x - longint'(m) * Q) >>> 32);
   endfunction

   function automatic longint powmod(input longint base, input int e);
      longint r, bb;
      int     ee;
      r = 1; bb = base % Q; ee = e;
      while (ee > 0) begin
         if (ee % 2 == 1) r = (r * bb) % Q;
         bb = (bb * bb) % Q;
         ee = ee / 2;
      end
      return r;
   endfunction

   // Montgomery-form powers of the 512th root 1753 in bit-reversed order, centred around zero
   task automatic gen_zetas();
      int     rev;
      longint z;
      for (int kk = 0; kk < 256; kk++) begin
         rev = 0;
         for (int bi = 0; bi < 8; bi++) if (((kk >> bi) & 1) == 1) rev = rev | (1 << (7 - bi));
         z = (R_MOD_Q * powmod(1753, rev)) % Q;
         if (z > Q / 2) z -= Q;
         zetas[kk] = int'(z);
      end
   endtask

   task automatic ref_invntt(input int a_in[256], output int r[256]);
      int a[256];
      int k, t, zeta, j, st, len;
      a = a_in;
      k = 256;
      for (len = 1; len < 256; len = len * 2) begin
         for (st = 0; st < 256; st = j + len) begin
            k--;
            zeta = -zetas[k];
            for (j = st; j < st + len; j++) begin
               t          = a[j];
               a[j]       = t + a[j+len];
               a[j+len]   = t - a[j+len];
               a[j+len]   = mont(longint'(zeta) * a[j+len]);
            end
         end
      end
      for (j = 0; j < 256; j++) a[j] = mont(longint'(41978) * a[j]);
      r = a;
   endtask

   task automatic ref_ntt(input int a_in[256], output int r[256]);
      int a[256];
      int k, t, zeta, j, st, len;
      a = a_in;
      k = 0;
      for (len = 128; len > 0; len = len / 2) begin
         for (st = 0; st < 256; st = j + len) begin
            k++;
            zeta = zetas[k];
            for (j = st; j < st + len; j++) begin
               t        = mont(longint'(zeta) * a[j+len]);
               a[j+len] = a[j] - t;
               a[j]     = a[j] + t;
            end
         end
      end
      r = a;
   endtask

   task automatic drive_inp(input int v[256]);
      for (int i = 0; i < 256; i++) inp[i*32 +: 32] = v[i];
   endtask

   task automatic read_out(output int got[256]);
      for (int i = 0; i < 256; i++) got[i] = out[i*32 +: 32];
   endtask

   task automatic wait_done(output int edge_no);
      int n;
      n = 0;
      edge_no = -1;
      while (n < 1300 && done !== 1'b1) begin
         @(negedge clock);
         n++;
      end
      if (done === 1'b1) edge_no = cyc;
      else check_eq("done_timeout", 0, 1);
   endtask

   task automatic compare_vec(input string tag, input int got[256], input int exp_v[256]);
      int bad;
      bad = -1;
      for (int i = 0; i < 256; i++) if (got[i] !== exp_v[i] && bad < 0) bad = i;
      if (bad < 0) bad = 0;
      check_eq($sformatf("%s[%0d]", tag, bad), got[bad], exp_v[bad]);
   endtask

   // Expects the DUT in WAIT_START; leaves it back in WAIT_START
   task automatic run_vec(input int v[256], input string tag, output int got[256]);
      int mref[256];
      int ed;
      drive_inp(v);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check_eq({tag, "_rd_ready"}, rd_ready, 1);
      wait_done(ed);
      read_out(got);
      ref_invntt(v, mref);
      compare_vec(tag, got, mref);
      @(negedge clock);
   endtask

   initial begin
      int v[256], got[256], mref[256], tmp[256];
      int bv[3][256];
      int ed[3];
      int e0, edz, nz, bad, idx, cnt, wcnt;
      longint c;

      gen_zetas();

      repeat (3) @(negedge clock);
      check_eq("rst_rd_ready", rd_ready, 0);
      check_eq("rst_rd_done", rd_done, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_wr_done", wr_done, 0);
      check_eq("rst_out_zero", |out, 0);
      reset = 1'b1;
      repeat (3) @(negedge clock);

      // all-zero input with latency and handshake timing
      for (int i = 0; i < 256; i++) v[i] = 0;
      drive_inp(v);
      start = 1'b1;
      @(negedge clock);
      e0 = cyc;
      start = 1'b0;
      check_eq("zero_rd_ready", rd_ready, 1);
      check_eq("zero_rd_done_low", rd_done, 0);
      @(negedge clock);
      check_eq("zero_rd_done", rd_done, 1);
      check_eq("zero_rd_ready_pulse", rd_ready, 0);
      wait_done(edz);
      check_eq("zero_latency", edz - e0, LAT);
      read_out(got);
      nz = 0;
      for (int i = 0; i < 256; i++) if (got[i] != 0) nz++;
      check_eq("zero_out_nonzero", nz, 0);
      @(negedge clock);
      check_eq("zero_done_pulse", done, 0);
      check_eq("zero_wr_done", wr_done, 1);

      // all-ones input collapses onto coefficient 0
      for (int i = 0; i < 256; i++) v[i] = 1;
      run_vec(v, "ones", got);
      check_eq("ones_out0_cong", modq(got[0]), R_MOD_Q);
      check_eq("ones_out0_range", (got[0] < Q && got[0] > -Q), 1);
      nz = 0;
      for (int i = 1; i < 256; i++) if (got[i] != 0) nz++;
      check_eq("ones_tail_nonzero", nz, 0);

      // forward then inverse returns i scaled by the Montgomery factor
      for (int i = 0; i < 256; i++) tmp[i] = i;
      ref_ntt(tmp, v);
      for (int i = 0; i < 256; i++) begin
         c = modq(v[i]);
         if (c > Q / 2) c -= Q;
         v[i] = int'(c);
      end
      run_vec(v, "roundtrip", got);
      bad = -1;
      for (int i = 0; i < 256; i++) if (modq(got[i]) != modq(longint'(i) * R_MOD_Q) && bad < 0) bad = i;
      idx = (bad < 0) ? 255 : bad;
      check_eq($sformatf("rt_cong[%0d]", idx), modq(got[idx]), modq(longint'(idx) * R_MOD_Q));

      // reset in the middle of the butterfly phase
      for (int i = 0; i < 256; i++) v[i] = 1;
      drive_inp(v);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (501) @(negedge clock);
      check_eq("abort_rd_done_pre", rd_done, 1);
      reset = 1'b0;
      #1;
      check_eq("abort_rd_done_async", rd_done, 0);
      check_eq("abort_out_async", |out, 0);
      @(negedge clock);
      reset = 1'b1;
      cnt = 0;
      wcnt = 0;
      for (int n = 0; n < 1300; n++) begin
         @(negedge clock);
         if (done === 1'b1) cnt++;
         if (wr_done === 1'b1) wcnt++;
      end
      check_eq("abort_no_done", cnt, 0);
      check_eq("abort_no_wr_done", wcnt, 0);
      run_vec(v, "abort_rerun", got);
      check_eq("abort_rerun_out0_cong", modq(got[0]), R_MOD_Q);

      // start held high across three transforms
      for (int r = 0; r < 3; r++) for (int i = 0; i < 256; i++) bv[r][i] = int'($urandom);
      for (int i = 0; i < 256; i++) v[i] = bv[0][i];
      drive_inp(v);
      start = 1'b1;
      @(negedge clock);
      e0 = cyc;
      check_eq("b2b_rd_ready0", rd_ready, 1);
      for (int r = 0; r < 3; r++) begin
         wait_done(ed[r]);
         read_out(got);
         for (int i = 0; i < 256; i++) v[i] = bv[r][i];
         ref_invntt(v, mref);
         compare_vec($sformatf("b2b%0d", r), got, mref);
         if (r < 2) begin
            for (int i = 0; i < 256; i++) v[i] = bv[r+1][i];
            drive_inp(v);
         end else begin
            start = 1'b0;
         end
         @(negedge clock);
         if (r < 2) begin
            @(negedge clock);
            check_eq($sformatf("b2b_rd_ready%0d", r + 1), rd_ready, 1);
         end
      end
      check_eq("b2b_latency0", ed[0] - e0, LAT);
      check_eq("b2b_gap01", ed[1] - ed[0], PERIOD);
      check_eq("b2b_gap12", ed[2] - ed[1], PERIOD);

      // random full-range vectors
      for (int n = 0; n < NUM_RANDOM; n++) begin
         for (int i = 0; i < 256; i++) v[i] = int'($urandom);
         run_vec(v, $sformatf("rand%0d", n), got);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
